fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00003000, first fetch address after reset.
REQ-002 Parameter EXC_PC, default 32'h00004180, exception handler entry.
REQ-003 Parameters IMEM_LO/IMEM_HI, defaults 32'h00003000/32'h00006FFC, legal fetch range, inclusive.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 stall  in  1  hazard-unit hold; instruction presented to the decode register is not consumed.
REQ-007 br_taken  in  1 / br_target  in  32  decode-stage redirect.
REQ-008 exc_req  in  1  CP0 exception/interrupt entry request.
REQ-009 eret_req  in  1 / epc  in  32  return-from-exception redirect.
REQ-010 imem_req  out  1 / imem_addr  out  32  instruction memory read request, one-cycle pulse.
REQ-011 imem_rvalid  in  1 / imem_rdata  in  32  read response, arrives 1..N cycles after imem_req.
REQ-012 PC  out  32 / IM  out  32 / exccode_PC  out  5  instruction bundle for the decode register.
REQ-013 f_valid  out  1  bundle valid; decode register enable = f_valid & !stall.

Function
REQ-014 FSM states: S_REQ (issue), S_WAIT (await response), S_READY (bundle held).
REQ-015 S_REQ, PC word-aligned and within [IMEM_LO, IMEM_HI]: imem_req=1, imem_addr=PC, next state S_WAIT.
REQ-016 S_REQ, PC misaligned or out of range: no imem_req, IM<=0, exccode_PC<=5'd4 (AdEL), next state S_READY.
REQ-017 S_WAIT: on imem_rvalid, IM<=imem_rdata, exccode_PC<=0, next state S_READY; otherwise remain.
REQ-018 S_READY: f_valid=1; if stall=0, PC<=PC+4, next state S_REQ; if stall=1, PC/IM/exccode_PC hold.
REQ-019 f_valid is 0 in S_REQ and S_WAIT.
REQ-020 Best-case throughput is one instruction per 3 cycles (REQ, WAIT with rvalid, READY).
REQ-021 Redirect priority: exc_req > eret_req > br_taken; target EXC_PC, epc, br_target respectively.
REQ-022 exc_req and eret_req take effect regardless of stall; br_taken is ignored while stall=1.
REQ-023 Redirect in S_REQ or S_READY: PC<=target, next state S_REQ; the current bundle is dropped.
REQ-024 Redirect in S_WAIT: PC<=target, kill flag set; the next imem_rvalid is discarded; next state S_REQ.
REQ-025 Redirect and imem_rvalid in the same S_WAIT cycle: data discarded, PC<=target, next state S_REQ, kill flag not set.
REQ-026 A second redirect while the kill flag is set overwrites PC only; one response is still discarded.
REQ-027 PC+4 arithmetic is 32-bit modulo; wrap past IMEM_HI yields AdEL via REQ-016.

Reset
REQ-028 While reset=0: state S_REQ, PC=RESET_PC, IM=0, exccode_PC=0, f_valid=0, imem_req=0, kill flag=0.
REQ-029 Reset mid-S_WAIT abandons the outstanding read; no response is accepted until a new imem_req issues.
REQ-030 First imem_req occurs on the first rising edge after reset deasserts.

Structure
REQ-031 Shared package holds state encodings, EXC_PC, RESET_PC, IMEM bounds and the exccode constants (AdEL=4).
REQ-032 Single module, no sub-modules; the next-PC/priority select is an internal combinational block.

Verification
REQ-033 Reset release, rvalid 1 cycle after each req: PC 0x3000, 0x3004, 0x3008 with f_valid high every third cycle.
REQ-034 stall=1 for 4 cycles in S_READY at PC 0x3004: PC/IM hold, no imem_req; resume to 0x3008 one cycle after stall drops.
REQ-035 br_taken to 0x3100 in S_WAIT, rvalid 2 cycles later: stale data dropped, next imem_addr=0x3100, f_valid low until the 0x3100 response.
REQ-036 br_target 0x3002: no imem_req, IM=0, exccode_PC=4, f_valid=1.
REQ-037 exc_req, eret_req (epc=0x3010) and br_taken all high with stall=1: PC<=0x4180 next cycle.
REQ-038 eret_req alone with epc=0x3010 in S_READY: next imem_addr=0x3010; reset asserted mid-S_WAIT returns PC to 0x3000 asynchronously.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding, default
// address map and the exception codes the fetch stage can raise.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_PC_DEF   = 32'h0000_4180;
  localparam logic [31:0] IMEM_LO_DEF  = 32'h0000_3000;
  localparam logic [31:0] IMEM_HI_DEF  = 32'h0000_6FFC;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  // A fetch is legal only for a word-aligned PC inside the inclusive window.
  function automatic logic pc_legal(input logic [31:0] pc,
                                    input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (pc[1:0] == 2'b00) && (pc >= lo) && (pc <= hi);
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one memory read per instruction, holds the
// resulting bundle for decode and steers the PC on exceptions, eret and branches.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] EXC_PC   = EXC_PC_DEF,
  parameter logic [31:0] IMEM_LO  = IMEM_LO_DEF,
  parameter logic [31:0] IMEM_HI  = IMEM_HI_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] IM,
  output logic [4:0]  exccode_PC,
  output logic        f_valid
);

  fetch_state_e state;
  logic         kill;
  logic         redirect;
  logic [31:0]  redirect_pc;
  logic         fetch_ok;

  // Exceptions beat eret, eret beats branches; a stalled decode stage cannot branch.
  always_comb begin
    redirect    = 1'b0;
    redirect_pc = br_target;
    if (exc_req) begin
      redirect    = 1'b1;
      redirect_pc = EXC_PC;
    end else if (eret_req) begin
      redirect    = 1'b1;
      redirect_pc = epc;
    end else if (br_taken && !stall) begin
      redirect    = 1'b1;
      redirect_pc = br_target;
    end
  end

  assign fetch_ok  = pc_legal(PC, IMEM_LO, IMEM_HI);
  assign imem_req  = reset && (state == S_REQ) && fetch_ok && !redirect;
  assign imem_addr = PC;

  // The kill flag swallows the one response still in flight from an abandoned fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_REQ;
      PC         <= RESET_PC;
      IM         <= '0;
      exccode_PC <= EXC_NONE;
      f_valid    <= 1'b0;
      kill       <= 1'b0;
    end else begin
      if (imem_rvalid && kill) begin
        kill <= 1'b0;
      end
      case (state)
        S_REQ: begin
          if (redirect) begin
            PC <= redirect_pc;
          end else if (fetch_ok) begin
            state <= S_WAIT;
          end else begin
            IM         <= '0;
            exccode_PC <= EXC_ADEL;
            f_valid    <= 1'b1;
            state      <= S_READY;
          end
        end
        S_WAIT: begin
          if (redirect) begin
            PC    <= redirect_pc;
            state <= S_REQ;
            if (kill || !imem_rvalid) begin
              kill <= 1'b1;
            end
          end else if (imem_rvalid && !kill) begin
            IM         <= imem_rdata;
            exccode_PC <= EXC_NONE;
            f_valid    <= 1'b1;
            state      <= S_READY;
          end
        end
        S_READY: begin
          if (redirect) begin
            PC      <= redirect_pc;
            f_valid <= 1'b0;
            state   <= S_REQ;
          end else if (!stall) begin
            PC      <= PC + 32'd4;
            f_valid <= 1'b0;
            state   <= S_REQ;
          end
        end
        default: begin
          f_valid <= 1'b0;
          state   <= S_REQ;
        end
      endcase
    end
  end

endmodule
